sensor_conditioner: RTL and testbench

- Upstream stage of the irrigation controller top level.
- Takes the six raw field-sensor lines (three water-level probes, earth humidity, air humidity, low temperature) and passes each through a 2-flop synchronizer and a per-channel debouncer.
- Presents clean, registered levels to the controller, plus three status outputs:
  - a change strobe;
  - a sticky "settled" flag;
  - a registered water-level plausibility fault.

---
 rtl/sensor_conditioner.sv | 114 +++++++++++
 tb/tb_sensor_conditioner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronizes and debounces six field-sensor lines for the irrigation controller
// Also emits a change strobe, a sticky settled flag and a water-level plausibility fault.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNTER_WIDTH   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_low_water_level,
  input  logic raw_mid_water_level,
  input  logic raw_high_water_level,
  input  logic raw_earth_humidity,
  input  logic raw_air_humidity,
  input  logic raw_low_temperature,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic sensors_changed,
  output logic sensors_settled,
  output logic water_level_fault
);

  localparam int NCH = 6;
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST    = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] SETTLE_DONE = COUNTER_WIDTH'(DEBOUNCE_CYCLES);

  logic [NCH-1:0]           raw;
  logic [NCH-1:0]           sync1_q, sync2_q;
  logic [NCH-1:0]           level_q, level_d;
  logic [NCH-1:0]           update;
  logic [COUNTER_WIDTH-1:0] cnt_q [NCH];
  logic [COUNTER_WIDTH-1:0] cnt_d [NCH];
  logic [COUNTER_WIDTH-1:0] settle_q, settle_d;
  logic                     settled_q, settled_d;
  logic                     changed_q;
  logic                     fault_q, fault_d;
  logic                     all_quiet;

  // Bit order: 0 low, 1 mid, 2 high water level, 3 earth, 4 air, 5 low temperature.
  assign raw = {raw_low_temperature, raw_air_humidity, raw_earth_humidity,
                raw_high_water_level, raw_mid_water_level, raw_low_water_level};

  always_comb begin
    level_d = level_q;
    update  = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        update[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    all_quiet = (sync2_q == level_q);
    settle_d  = settle_q;
    settled_d = settled_q;
    if (!all_quiet) begin
      settle_d = '0;
    end else if (!settled_q && (settle_q < SETTLE_DONE)) begin
      settle_d = settle_q + 1'b1;
    end
    if (settle_d == SETTLE_DONE) begin
      settled_d = 1'b1;
    end

    // Levels must read as a thermometer code from low upwards.
    fault_d = (level_d[2] & ~level_d[1]) | (level_d[1] & ~level_d[0]) | (level_d[2] & ~level_d[0]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      settle_q  <= '0;
      settled_q <= 1'b0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      settle_q  <= settle_d;
      settled_q <= settled_d;
      changed_q <= |update;
      fault_q   <= fault_d;
    end
  end

  assign low_water_level   = level_q[0];
  assign mid_water_level   = level_q[1];
  assign high_water_level  = level_q[2];
  assign earth_humidity    = level_q[3];
  assign air_humidity      = level_q[4];
  assign low_temperature   = level_q[5];
  assign sensors_changed   = changed_q;
  assign sensors_settled   = settled_q;
  assign water_level_fault = fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - directed bench for sensor_conditioner
// Main instance uses DEBOUNCE_CYCLES=4; a second instance covers DEBOUNCE_CYCLES=1.
module tb_sensor_conditioner;

  logic       clock;
  logic       reset;
  logic [5:0] raw;
  logic [5:0] raw1;
  logic       chg, settled, fault;
  logic       chg1, settled1, fault1;
  logic [5:0] lv, lv1;
  int         checks;
  int         failures;

  sensor_conditioner #(.DEBOUNCE_CYCLES(4), .COUNTER_WIDTH(5)) dut (
    .clock                (clock),
    .reset                (reset),
    .raw_low_water_level  (raw[0]),
    .raw_mid_water_level  (raw[1]),
    .raw_high_water_level (raw[2]),
    .raw_earth_humidity   (raw[3]),
    .raw_air_humidity     (raw[4]),
    .raw_low_temperature  (raw[5]),
    .low_water_level      (lv[0]),
    .mid_water_level      (lv[1]),
    .high_water_level     (lv[2]),
    .earth_humidity       (lv[3]),
    .air_humidity         (lv[4]),
    .low_temperature      (lv[5]),
    .sensors_changed      (chg),
    .sensors_settled      (settled),
    .water_level_fault    (fault)
  );

  sensor_conditioner #(.DEBOUNCE_CYCLES(1), .COUNTER_WIDTH(1)) dut1 (
    .clock                (clock),
    .reset                (reset),
    .raw_low_water_level  (raw1[0]),
    .raw_mid_water_level  (raw1[1]),
    .raw_high_water_level (raw1[2]),
    .raw_earth_humidity   (raw1[3]),
    .raw_air_humidity     (raw1[4]),
    .raw_low_temperature  (raw1[5]),
    .low_water_level      (lv1[0]),
    .mid_water_level      (lv1[1]),
    .high_water_level     (lv1[2]),
    .earth_humidity       (lv1[3]),
    .air_humidity         (lv1[4]),
    .low_temperature      (lv1[5]),
    .sensors_changed      (chg1),
    .sensors_settled      (settled1),
    .water_level_fault    (fault1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw   = 6'h3F;
    raw1  = 6'h00;
    repeat (3) tick();
    checks++;
    if ({lv, chg, settled, fault} !== 9'd0) begin
      failures++;
      $display("FAIL reset_state: got lv=%h chg=%b settled=%b fault=%b, want all 0", lv, chg, settled, fault);
    end
    reset = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (lv !== ((t >= 6) ? 6'h3F : 6'h00) || chg !== (t == 6) || settled !== (t >= 10) || fault !== 1'b0) begin
        failures++;
        $display("FAIL release_edge%0d: got lv=%h chg=%b settled=%b fault=%b", t, lv, chg, settled, fault);
      end
    end
  endtask

  task automatic test_glitch();
    raw[3] = 1'b0;
    repeat (8) tick();
    checks++;
    if (lv[3] !== 1'b0) begin
      failures++;
      $display("FAIL earth_low_setup: got %b want 0", lv[3]);
    end
    for (int t = 0; t < 12; t++) begin
      raw[3] = (t < 3);
      tick();
      checks++;
      if (lv[3] !== 1'b0 || chg !== 1'b0) begin
        failures++;
        $display("FAIL earth_glitch_t%0d: got earth=%b chg=%b want 0 0", t, lv[3], chg);
      end
    end
  endtask

  task automatic test_restart();
    raw[4] = 1'b0;
    repeat (8) tick();
    checks++;
    if (lv[4] !== 1'b0) begin
      failures++;
      $display("FAIL air_low_setup: got %b want 0", lv[4]);
    end
    for (int t = 0; t < 4; t++) begin
      raw[4] = (t < 3);
      tick();
      checks++;
      if (lv[4] !== 1'b0) begin
        failures++;
        $display("FAIL air_pre_t%0d: got %b want 0", t, lv[4]);
      end
    end
    raw[4] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (lv[4] !== (t >= 6) || chg !== (t == 6)) begin
        failures++;
        $display("FAIL air_restart_t%0d: got air=%b chg=%b want %b %b", t, lv[4], chg, (t >= 6), (t == 6));
      end
    end
  endtask

  task automatic test_fault();
    raw[0] = 1'b0;
    raw[2] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (lv[2:0] !== ((t < 6) ? 3'b111 : 3'b010) || fault !== (t >= 6) || chg !== (t == 6)) begin
        failures++;
        $display("FAIL fault_set_t%0d: got lvl=%b fault=%b chg=%b", t, lv[2:0], fault, chg);
      end
    end
    raw[0] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (lv[2:0] !== ((t < 6) ? 3'b010 : 3'b011) || fault !== (t < 6)) begin
        failures++;
        $display("FAIL fault_clear_t%0d: got lvl=%b fault=%b", t, lv[2:0], fault);
      end
    end
  endtask

  task automatic test_reset_mid();
    raw[2] = 1'b1;
    raw[3] = 1'b1;
    repeat (8) tick();
    checks++;
    if (lv !== 6'h3F) begin
      failures++;
      $display("FAIL all_high_setup: got %h want 3f", lv);
    end
    raw[4] = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({lv, chg, settled, fault} !== 9'd0) begin
      failures++;
      $display("FAIL reset_mid: got lv=%h chg=%b settled=%b fault=%b, want all 0", lv, chg, settled, fault);
    end
    reset = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (lv !== ((t >= 6) ? 6'h2F : 6'h00) || chg !== (t == 6) || settled !== (t >= 10)) begin
        failures++;
        $display("FAIL rerelease_t%0d: got lv=%h chg=%b settled=%b", t, lv, chg, settled);
      end
    end
  endtask

  task automatic test_settled_toggle();
    for (int t = 1; t <= 12; t++) begin
      raw[5] = (t > 4);
      tick();
      checks++;
      if (lv[5] !== (t < 6 || t >= 10) || settled !== 1'b1) begin
        failures++;
        $display("FAIL temp_4sample_t%0d: got temp=%b settled=%b", t, lv[5], settled);
      end
    end
    for (int t = 1; t <= 10; t++) begin
      raw[5] = (t > 3);
      tick();
      checks++;
      if (lv[5] !== 1'b1 || settled !== 1'b1) begin
        failures++;
        $display("FAIL temp_3sample_t%0d: got temp=%b settled=%b want 1 1", t, lv[5], settled);
      end
    end
    raw[5] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (lv[5] !== (t < 6) || settled !== 1'b1) begin
        failures++;
        $display("FAIL temp_hold_t%0d: got temp=%b settled=%b", t, lv[5], settled);
      end
    end
  endtask

  task automatic test_dc1();
    raw1[3] = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (lv1[3] !== (t >= 3) || chg1 !== (t == 3)) begin
        failures++;
        $display("FAIL dc1_rise_t%0d: got earth=%b chg=%b", t, lv1[3], chg1);
      end
    end
    for (int t = 1; t <= 5; t++) begin
      raw1[3] = (t != 1);
      tick();
      checks++;
      if (lv1[3] !== (t != 3) || chg1 !== (t == 3 || t == 4)) begin
        failures++;
        $display("FAIL dc1_pulse_t%0d: got earth=%b chg=%b", t, lv1[3], chg1);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    raw      = 6'h00;
    raw1     = 6'h00;
    test_reset();
    test_glitch();
    test_restart();
    test_fault();
    test_reset_mid();
    test_settled_toggle();
    test_dc1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
